// File: rtl/bird_column.sv
// Bird position tracker for a single LED column: flap lifts the bird, gravity
// ticks pull it down, and touching the floor latches a sticky DEAD state.
module bird_column #(
    parameter int ROWS       = 8,
    parameter int START_ROW  = 4,
    parameter int FLAP_ROWS  = 1,
    parameter int FALL_TICKS = 2,
    localparam int POS_W     = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pause,
    input  logic             flap,
    input  logic             gravity,
    output logic [POS_W-1:0] pos,
    output logic [ROWS-1:0]  rows,
    output logic             dead
);

    localparam int FC_W = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;

    localparam logic [POS_W:0]   TOP_EXT   = (POS_W+1)'(ROWS - 1);
    localparam logic [POS_W:0]   FLAP_EXT  = (POS_W+1)'(FLAP_ROWS);
    localparam logic [POS_W-1:0] START_POS = POS_W'(START_ROW);
    localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(FALL_TICKS - 1);
    localparam logic [ROWS-1:0]  ONE_HOT0  = ROWS'(1);

    typedef enum logic [0:0] {
        ST_FLY  = 1'b0,
        ST_DEAD = 1'b1
    } state_t;

    state_t           state_q;
    logic [POS_W-1:0] pos_q;
    logic [FC_W-1:0]  fall_cnt_q;

    logic [POS_W:0]   flap_sum_s;
    logic [POS_W-1:0] flap_pos_s;

    // Flap target: the sum is one bit wider so it can be clamped without wrapping.
    always_comb begin
        flap_sum_s = {1'b0, pos_q} + FLAP_EXT;
        if (flap_sum_s > TOP_EXT) begin
            flap_pos_s = TOP_EXT[POS_W-1:0];
        end else begin
            flap_pos_s = flap_sum_s[POS_W-1:0];
        end
    end

    // Flight state machine: reset beats pause, pause beats everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FLY;
            pos_q      <= START_POS;
            fall_cnt_q <= {FC_W{1'b0}};
        end else if (pause) begin
            state_q    <= state_q;
            pos_q      <= pos_q;
            fall_cnt_q <= fall_cnt_q;
        end else begin
            case (state_q)
                ST_FLY: begin
                    if (flap) begin
                        pos_q      <= flap_pos_s;
                        fall_cnt_q <= {FC_W{1'b0}};
                    end else if (gravity) begin
                        if (fall_cnt_q != FC_LAST) begin
                            fall_cnt_q <= fall_cnt_q + FC_W'(1);
                        end else begin
                            fall_cnt_q <= {FC_W{1'b0}};
                            if (pos_q != {POS_W{1'b0}}) begin
                                pos_q <= pos_q - POS_W'(1);
                            end else begin
                                state_q <= ST_DEAD;
                            end
                        end
                    end else begin
                        pos_q      <= pos_q;
                        fall_cnt_q <= fall_cnt_q;
                    end
                end
                ST_DEAD: begin
                    state_q    <= ST_DEAD;
                    pos_q      <= pos_q;
                    fall_cnt_q <= fall_cnt_q;
                end
                default: begin
                    state_q    <= ST_FLY;
                    pos_q      <= START_POS;
                    fall_cnt_q <= {FC_W{1'b0}};
                end
            endcase
        end
    end

    // Output decode of the registered state; pos_q never exceeds ROWS-1 so rows is one-hot.
    always_comb begin
        pos  = pos_q;
        rows = ONE_HOT0 << pos_q;
        dead = (state_q == ST_DEAD);
    end

endmodule
